free_list_alloc_ctrl: RTL and testbench
=======================================

Name: free_list_alloc_ctrl

Overview:
- Scheduler in front of the 3-port physical-tag free list (circular_buffer_3port).
- Shares the three free-list read ports among three in-order rename lanes.
- Sequences tag returns from commit and flush recovery onto the three write ports without ever overflowing the free list.
- Holds returns in a backlog counter when write capacity is short, and blocks allocation while flush recovery drains.

Parameters:
- BUFFER_DEPTH, 32: free-list depth (power of 2); must match the attached free list.
- ADDR_WIDTH, $clog2(BUFFER_DEPTH): tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alloc_req  in  3  per-lane request for one new tag; bit 0 is the oldest lane.
- rename_ready  in  1  downstream rename stage accepts this cycle.
- alloc_grant  out  3  lane granted a tag this cycle.
- alloc_tag_0/1/2  out  ADDR_WIDTH  granted tag per lane; 0 when that lane is not granted.
- alloc_stall  out  1  some requesting lane was not granted.
- fl_read_en_0/1/2  out  1  to free-list read enables.
- fl_read_data_0/1/2  in  ADDR_WIDTH+1  from the free list; MSB is the valid marker.
- fl_read_valid_0/1/2  in  1  from the free list.
- fl_buffer_count  in  ADDR_WIDTH+1  free-list occupancy.
- fl_write_en_0/1/2  out  1  to free-list write enables.
- commit_free_en  in  3  committed instructions returning one tag each.
- flush  in  1  pipeline flush pulse.
- flush_free_count  in  ADDR_WIDTH+1  speculative tags to return on flush.
- recovering  out  1  FSM is in RECOVER.
- pending_free  out  ADDR_WIDTH+1  return backlog.
- overflow_err  out  1  sticky: backlog exceeded BUFFER_DEPTH.

Behaviour:
- Reset (async, rst=1):
  - state=RUN, pending_free=0, overflow_err=0.
  - All enables, grants and tags are 0; alloc_stall=0.
  - The free list comes out of reset full, so no write capacity exists until tags are allocated.
- FSM states: RUN and RECOVER.
  - RUN -> RECOVER when flush=1.
  - RECOVER -> RUN at the edge where pending_next==0 and flush=0.
  - flush in RECOVER adds its count and stays in RECOVER.
- Allocation (combinational, zero latency; only in RUN, with flush=0 and rename_ready=1, else grants=0):
  - Requests are granted strictly in lane order.
  - Lane k is granted iff alloc_req[k]=1, every lower requesting lane is granted, and the grants so far are below fl_buffer_count.
  - A gap lane (req=0) does not block higher lanes.
  - fl_read_en_k = alloc_grant[k].
  - alloc_tag_k = fl_read_data_k[ADDR_WIDTH-1:0] when granted.
  - Invariant: fl_read_valid_k == alloc_grant[k]. A mismatch is a simulation error (assertion only).
  - alloc_stall = |(alloc_req & ~alloc_grant). It is asserted in RECOVER, on a flush cycle, or when rename_ready=0, whenever any request is present.
- Release (combinational enables, registered backlog):
  - in_cnt = popcount(commit_free_en) + (flush ? flush_free_count : 0).
  - avail = pending_free + in_cnt.
  - room = BUFFER_DEPTH - fl_buffer_count; this uses the current count, and same-cycle reads are not credited.
  - w = min(3, avail, room).
  - fl_write_en_0..w-1 = 1, in port order.
  - pending_next = avail - w, computed at ADDR_WIDTH+2 bits.
  - If pending_next > BUFFER_DEPTH: set overflow_err and saturate pending_free at BUFFER_DEPTH.
  - Releases run in both states; commit frees arriving during RECOVER join the same backlog.
- Allocation and release happen independently in the same cycle. Free-list pointer updates land at the next edge.
- recovering = (state==RECOVER), a registered output.

Test Plan:
- Allocate from a full list: reset, then alloc_req=3'b111 with rename_ready=1 -> grant=111, tags 0,1,2. Next cycle, same request -> tags 3,4,5; fl_buffer_count 32->29->26.
- Gap lane with a low list: drain to fl_buffer_count=2, then alloc_req=3'b101 -> grant=101, alloc_stall=0. Then alloc_req=3'b111 with count=2 -> grant=011, alloc_stall=1.
- Backpressure: alloc_req=3'b111, rename_ready=0 -> grant=000, all fl_read_en=0, alloc_stall=1, read pointer unchanged.
- Capacity-limited commit: count=31, commit_free_en=3'b111 -> fl_write_en=1,0,0 and pending_free=2. It drains by one write per cycle as room allows, then returns to 0.
- Flush recovery: after 10 allocations, flush=1 with flush_free_count=7 -> recovering=1 next cycle.
  - Writes proceed 3,3,1 over three cycles, then back to RUN.
  - alloc_req during recovery -> grant=000, alloc_stall=1.
- Reset mid-recovery: assert rst with pending_free=5 -> immediately state=RUN, pending_free=0, all enables 0, overflow_err=0.

Source files
------------

// File: rtl/free_list_alloc_ctrl.sv
// Allocation/release scheduler in front of a 3-port physical-tag free list.
// Latency: grants, tags and write enables are combinational (0 cycles); backlog and FSM update at the next edge.
// Backpressure: no grants when rename_ready=0, on flush or in RECOVER; short write room parks returns in pending_free.
module free_list_alloc_ctrl #(
    parameter int BUFFER_DEPTH = 32,
    parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    // rename lanes, bit 0 is the oldest lane
    input  logic [2:0]            alloc_req,
    input  logic                  rename_ready,
    output logic [2:0]            alloc_grant,
    output logic [ADDR_WIDTH-1:0] alloc_tag_0,
    output logic [ADDR_WIDTH-1:0] alloc_tag_1,
    output logic [ADDR_WIDTH-1:0] alloc_tag_2,
    output logic                  alloc_stall,

    // free-list read side
    output logic                  fl_read_en_0,
    output logic                  fl_read_en_1,
    output logic                  fl_read_en_2,
    input  logic [ADDR_WIDTH:0]   fl_read_data_0,
    input  logic [ADDR_WIDTH:0]   fl_read_data_1,
    input  logic [ADDR_WIDTH:0]   fl_read_data_2,
    input  logic                  fl_read_valid_0,
    input  logic                  fl_read_valid_1,
    input  logic                  fl_read_valid_2,
    input  logic [ADDR_WIDTH:0]   fl_buffer_count,

    // free-list write side
    output logic                  fl_write_en_0,
    output logic                  fl_write_en_1,
    output logic                  fl_write_en_2,

    // tag returns
    input  logic [2:0]            commit_free_en,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   flush_free_count,

    // status
    output logic                  recovering,
    output logic [ADDR_WIDTH:0]   pending_free,
    output logic                  overflow_err
);

    // Count width matches the free-list occupancy; backlog arithmetic gets one
    // extra bit so a large flush on top of a full backlog cannot wrap.
    localparam int CW = ADDR_WIDTH + 1;
    localparam int PW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic          alloc_ok;
    logic          blocked;
    logic [CW-1:0] granted;
    logic [2:0]    grant_c;

    logic [PW-1:0] commit_cnt;
    logic [PW-1:0] in_cnt;
    logic [PW-1:0] avail;
    logic [PW-1:0] room;
    logic [PW-1:0] wr_cnt;
    logic [PW-1:0] pending_next;

    // ------------------------------------------------------------------
    // Allocation
    // ------------------------------------------------------------------

    // In-order grant: a requesting lane that misses blocks every younger
    // requesting lane, while idle lanes are simply skipped.
    always_comb begin
        grant_c  = '0;
        granted  = '0;
        blocked  = 1'b0;
        alloc_ok = !rst && (state == ST_RUN) && !flush && rename_ready;
        for (int k = 0; k < 3; k++) begin
            if (alloc_req[k]) begin
                if (alloc_ok && !blocked && (granted < fl_buffer_count)) begin
                    grant_c[k] = 1'b1;
                    granted    = granted + CW'(1);
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    assign alloc_grant  = grant_c;
    assign fl_read_en_0 = grant_c[0];
    assign fl_read_en_1 = grant_c[1];
    assign fl_read_en_2 = grant_c[2];

    // Tags are forced to zero on ungranted lanes so rename never latches a stale value.
    assign alloc_tag_0 = grant_c[0] ? fl_read_data_0[ADDR_WIDTH-1:0] : '0;
    assign alloc_tag_1 = grant_c[1] ? fl_read_data_1[ADDR_WIDTH-1:0] : '0;
    assign alloc_tag_2 = grant_c[2] ? fl_read_data_2[ADDR_WIDTH-1:0] : '0;

    assign alloc_stall = !rst && (|(alloc_req & ~grant_c));

    // ------------------------------------------------------------------
    // Release
    // ------------------------------------------------------------------

    // Write budget: never more than three ports, the tags on hand, or the
    // room left in the list. Room uses the current occupancy only, so a
    // same-cycle read never lets a write land on a still-occupied slot.
    always_comb begin
        commit_cnt = PW'(commit_free_en[0]) + PW'(commit_free_en[1]) + PW'(commit_free_en[2]);
        in_cnt     = commit_cnt + (flush ? PW'(flush_free_count) : '0);
        avail      = PW'(pending_free) + in_cnt;
        room       = DEPTH_P - PW'(fl_buffer_count);
        wr_cnt     = PW'(3);
        if (avail < wr_cnt) begin
            wr_cnt = avail;
        end
        if (room < wr_cnt) begin
            wr_cnt = room;
        end
        pending_next = avail - wr_cnt;
    end

    // Write ports fill from port 0 upward.
    assign fl_write_en_0 = !rst && (wr_cnt > PW'(0));
    assign fl_write_en_1 = !rst && (wr_cnt > PW'(1));
    assign fl_write_en_2 = !rst && (wr_cnt > PW'(2));

    // Backlog register; a backlog beyond the list depth is impossible with
    // consistent tag accounting, so it saturates and raises a sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_free <= '0;
            overflow_err <= 1'b0;
        end else if (pending_next > DEPTH_P) begin
            pending_free <= DEPTH_C;
            overflow_err <= 1'b1;
        end else begin
            pending_free <= pending_next[CW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Recovery FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Leave recovery only once the backlog empties with no new flush arriving.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if ((pending_next == '0) && !flush) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Status decode straight from the state register.
    always_comb begin
        recovering = (state == ST_RECOVER);
    end

    // ------------------------------------------------------------------
    // Free-list handshake invariants
    // ------------------------------------------------------------------

    a_valid_0:  assert property (@(posedge clk) disable iff (rst) fl_read_valid_0 == alloc_grant[0]);
    a_valid_1:  assert property (@(posedge clk) disable iff (rst) fl_read_valid_1 == alloc_grant[1]);
    a_valid_2:  assert property (@(posedge clk) disable iff (rst) fl_read_valid_2 == alloc_grant[2]);
    a_marker_0: assert property (@(posedge clk) disable iff (rst) alloc_grant[0] |-> fl_read_data_0[ADDR_WIDTH]);
    a_marker_1: assert property (@(posedge clk) disable iff (rst) alloc_grant[1] |-> fl_read_data_1[ADDR_WIDTH]);
    a_marker_2: assert property (@(posedge clk) disable iff (rst) alloc_grant[2] |-> fl_read_data_2[ADDR_WIDTH]);

endmodule

// File: tb/tb_free_list_alloc_ctrl.sv
module tb_free_list_alloc_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    alloc_req;
    logic          rename_ready;
    logic [2:0]    alloc_grant;
    logic [AW-1:0] alloc_tag_0, alloc_tag_1, alloc_tag_2;
    logic          alloc_stall;
    logic          fl_read_en_0, fl_read_en_1, fl_read_en_2;
    logic [AW:0]   fl_read_data_0, fl_read_data_1, fl_read_data_2;
    logic          fl_read_valid_0, fl_read_valid_1, fl_read_valid_2;
    logic [AW:0]   fl_buffer_count;
    logic          fl_write_en_0, fl_write_en_1, fl_write_en_2;
    logic [2:0]    commit_free_en;
    logic          flush;
    logic [AW:0]   flush_free_count;
    logic          recovering;
    logic [AW:0]   pending_free;
    logic          overflow_err;

    always #5 clk = ~clk;

    free_list_alloc_ctrl #(.BUFFER_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .rename_ready(rename_ready), .alloc_grant(alloc_grant),
        .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1), .alloc_tag_2(alloc_tag_2),
        .alloc_stall(alloc_stall),
        .fl_read_en_0(fl_read_en_0), .fl_read_en_1(fl_read_en_1), .fl_read_en_2(fl_read_en_2),
        .fl_read_data_0(fl_read_data_0), .fl_read_data_1(fl_read_data_1), .fl_read_data_2(fl_read_data_2),
        .fl_read_valid_0(fl_read_valid_0), .fl_read_valid_1(fl_read_valid_1), .fl_read_valid_2(fl_read_valid_2),
        .fl_buffer_count(fl_buffer_count),
        .fl_write_en_0(fl_write_en_0), .fl_write_en_1(fl_write_en_1), .fl_write_en_2(fl_write_en_2),
        .commit_free_en(commit_free_en), .flush(flush), .flush_free_count(flush_free_count),
        .recovering(recovering), .pending_free(pending_free), .overflow_err(overflow_err)
    );

    // Behavioural free list: a circular array; enabled read ports pop in port order.
    logic [AW-1:0] fl_mem [DEPTH];
    int            fl_rd, fl_wr, fl_cnt, next_ret;
    logic [2:0]    rv;
    logic [AW:0]   rdat [3];

    assign fl_buffer_count = (AW+1)'(fl_cnt);
    assign fl_read_valid_0 = rv[0];
    assign fl_read_valid_1 = rv[1];
    assign fl_read_valid_2 = rv[2];
    assign fl_read_data_0  = rdat[0];
    assign fl_read_data_1  = rdat[1];
    assign fl_read_data_2  = rdat[2];

    always_comb begin
        int j;
        logic [2:0] en;
        rv = '0;
        for (int k = 0; k < 3; k++) rdat[k] = '0;
        en = {fl_read_en_2, fl_read_en_1, fl_read_en_0};
        j = 0;
        for (int k = 0; k < 3; k++) begin
            if (en[k] && (j < fl_cnt)) begin
                rv[k]   = 1'b1;
                rdat[k] = {1'b1, fl_mem[(fl_rd + j) % DEPTH]};
                j++;
            end
        end
    end

    // Reference model of the controller: backlog as an integer, recovery as a flag.
    int m_pend;
    bit m_rec, m_ovf;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0] req;
        logic       rdy;
        logic [2:0] cfe;
        logic       fl;
        int         ffc;
        logic [2:0] e_grant;
        logic       e_stall;
        logic [2:0] e_we;
        int         e_pend;
        logic       e_rec;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) fl_mem[i] = AW'(i);
        fl_rd = 0; fl_wr = 0; fl_cnt = DEPTH; next_ret = 0;
        m_pend = 0; m_rec = 0; m_ovf = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_req = '0; rename_ready = 1'b0; commit_free_en = '0; flush = 1'b0; flush_free_count = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive inputs at the negedge and let combinational outputs settle.
    task automatic apply(input logic [2:0] req, input logic rdy, input logic [2:0] cfe,
                         input logic fl, input int ffc);
        alloc_req = req; rename_ready = rdy; commit_free_en = cfe;
        flush = fl; flush_free_count = (AW+1)'(ffc);
        #1;
    endtask

    // Compare every output against the model, clock once, advance model and free list.
    task automatic step_check();
        logic [2:0]    eg;
        logic [AW-1:0] et [3];
        int budget, j, in_cnt, avail, room, w, nxt, rds, wrs;
        bit ok, fl_now;
        eg = '0;
        for (int k = 0; k < 3; k++) et[k] = '0;
        ok = !m_rec && !flush && rename_ready;
        budget = fl_cnt;
        for (int k = 0; k < 3; k++) begin
            if (alloc_req[k]) begin
                if (ok && budget > 0) begin eg[k] = 1'b1; budget--; end
                else ok = 0;
            end
        end
        j = 0;
        for (int k = 0; k < 3; k++) if (eg[k]) begin et[k] = fl_mem[(fl_rd + j) % DEPTH]; j++; end
        in_cnt = $countones(commit_free_en) + (flush ? int'(flush_free_count) : 0);
        avail  = m_pend + in_cnt;
        room   = DEPTH - fl_cnt;
        w = 3;
        if (avail < w) w = avail;
        if (room < w) w = room;
        chk("grant",    32'(alloc_grant), 32'(eg));
        chk("tag0",     32'(alloc_tag_0), 32'(et[0]));
        chk("tag1",     32'(alloc_tag_1), 32'(et[1]));
        chk("tag2",     32'(alloc_tag_2), 32'(et[2]));
        chk("stall",    32'(alloc_stall), 32'(|(alloc_req & ~eg)));
        chk("read_en",  32'({fl_read_en_2, fl_read_en_1, fl_read_en_0}), 32'(eg));
        chk("write_en", 32'({fl_write_en_2, fl_write_en_1, fl_write_en_0}), 32'((1 << w) - 1));
        chk("pending",  32'(pending_free), 32'(m_pend));
        chk("recov",    32'(recovering), 32'(m_rec));
        chk("ovf",      32'(overflow_err), 32'(m_ovf));
        rds = $countones(rv);
        wrs = $countones({fl_write_en_2, fl_write_en_1, fl_write_en_0});
        fl_now = flush;
        @(posedge clk);
        #1;
        nxt = avail - w;
        if (nxt > DEPTH) begin m_ovf = 1; m_pend = DEPTH; end
        else m_pend = nxt;
        m_rec = m_rec ? !(nxt == 0 && !fl_now) : fl_now;
        fl_rd  = (fl_rd + rds) % DEPTH;
        fl_cnt = fl_cnt - rds;
        for (int i = 0; i < wrs; i++) begin
            fl_mem[fl_wr] = next_ret[AW-1:0];
            fl_wr = (fl_wr + 1) % DEPTH;
            fl_cnt++;
            next_ret++;
        end
        chk("fl_no_overflow", 32'(fl_cnt <= DEPTH), 32'd1);
        if (fl_cnt > DEPTH) fl_cnt = DEPTH;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{3'b111, 1'b1, 3'b000, 1'b0, 0, 3'b111, 1'b0, 3'b000, 0, 1'b0};
        tbl[1] = '{3'b111, 1'b1, 3'b000, 1'b0, 0, 3'b111, 1'b0, 3'b000, 0, 1'b0};
        tbl[2] = '{3'b111, 1'b0, 3'b000, 1'b0, 0, 3'b000, 1'b1, 3'b000, 0, 1'b0};
        tbl[3] = '{3'b110, 1'b1, 3'b011, 1'b0, 0, 3'b110, 1'b0, 3'b011, 0, 1'b0};
        tbl[4] = '{3'b000, 1'b1, 3'b000, 1'b1, 5, 3'b000, 1'b0, 3'b111, 2, 1'b1};
        tbl[5] = '{3'b111, 1'b1, 3'b001, 1'b0, 0, 3'b000, 1'b1, 3'b111, 0, 1'b0};
        tbl[6] = '{3'b101, 1'b1, 3'b000, 1'b0, 0, 3'b101, 1'b0, 3'b000, 0, 1'b0};
        tbl[7] = '{3'b111, 1'b1, 3'b000, 1'b0, 0, 3'b111, 1'b0, 3'b000, 0, 1'b0};
        tbl[8] = '{3'b111, 1'b1, 3'b001, 1'b1, 2, 3'b000, 1'b1, 3'b111, 0, 1'b1};
        tbl[9] = '{3'b000, 1'b1, 3'b000, 1'b0, 0, 3'b000, 1'b0, 3'b000, 0, 1'b0};

        // Reset state with requests present: everything must stay quiet.
        rst = 1'b1;
        model_reset();
        alloc_req = 3'b111; rename_ready = 1'b1; commit_free_en = 3'b111; flush = 1'b0; flush_free_count = '0;
        #2;
        chk("rst_grant", 32'(alloc_grant), 32'd0);
        chk("rst_stall", 32'(alloc_stall), 32'd0);
        chk("rst_we",    32'({fl_write_en_2, fl_write_en_1, fl_write_en_0}), 32'd0);
        chk("rst_pend",  32'(pending_free), 32'd0);
        chk("rst_recov", 32'(recovering), 32'd0);
        chk("rst_ovf",   32'(overflow_err), 32'd0);
        do_reset();

        // Allocate from a full list.
        apply(3'b111, 1, 3'b000, 0, 0);
        chk("full_grant", 32'(alloc_grant), 32'b111);
        chk("full_tags",  32'({alloc_tag_2, alloc_tag_1, alloc_tag_0}), 32'({5'd2, 5'd1, 5'd0}));
        step_check();
        apply(3'b111, 1, 3'b000, 0, 0);
        chk("full_tags2", 32'({alloc_tag_2, alloc_tag_1, alloc_tag_0}), 32'({5'd5, 5'd4, 5'd3}));
        step_check();
        chk("count_26", 32'(fl_buffer_count), 32'd26);

        // Backpressure holds the read pointer.
        apply(3'b111, 0, 3'b000, 0, 0);
        chk("bp_grant", 32'(alloc_grant), 32'd0);
        chk("bp_stall", 32'(alloc_stall), 32'd1);
        step_check();
        chk("bp_count", 32'(fl_buffer_count), 32'd26);

        // Gap lane with only two tags left.
        for (int i = 0; i < 8; i++) begin apply(3'b111, 1, 3'b000, 0, 0); step_check(); end
        apply(3'b101, 1, 3'b000, 0, 0);
        chk("gap_grant", 32'(alloc_grant), 32'b101);
        chk("gap_stall", 32'(alloc_stall), 32'd0);
        apply(3'b111, 1, 3'b000, 0, 0);
        chk("low_grant", 32'(alloc_grant), 32'b011);
        chk("low_stall", 32'(alloc_stall), 32'd1);
        step_check();

        // Refill to 31, then a commit larger than the remaining room.
        for (int i = 0; i < 10; i++) begin apply(3'b000, 1, 3'b111, 0, 0); step_check(); end
        apply(3'b000, 1, 3'b001, 0, 0); step_check();
        apply(3'b000, 1, 3'b111, 0, 0);
        chk("cap_we", 32'({fl_write_en_2, fl_write_en_1, fl_write_en_0}), 32'b001);
        step_check();
        chk("cap_pend2", 32'(pending_free), 32'd2);
        apply(3'b001, 1, 3'b000, 0, 0); step_check();
        chk("cap_pend2b", 32'(pending_free), 32'd2);
        apply(3'b001, 1, 3'b000, 0, 0); step_check();
        chk("cap_pend1", 32'(pending_free), 32'd1);
        apply(3'b001, 1, 3'b000, 0, 0); step_check();
        chk("cap_pend0", 32'(pending_free), 32'd0);

        // Flush recovery after ten allocations: writes 3,3,1 then back to RUN.
        do_reset();
        for (int i = 0; i < 3; i++) begin apply(3'b111, 1, 3'b000, 0, 0); step_check(); end
        apply(3'b001, 1, 3'b000, 0, 0); step_check();
        apply(3'b000, 1, 3'b000, 1, 7);
        chk("fr_we0", 32'({fl_write_en_2, fl_write_en_1, fl_write_en_0}), 32'b111);
        step_check();
        chk("fr_recov", 32'(recovering), 32'd1);
        apply(3'b111, 1, 3'b000, 0, 0);
        chk("fr_grant", 32'(alloc_grant), 32'd0);
        chk("fr_stall", 32'(alloc_stall), 32'd1);
        chk("fr_we1",   32'({fl_write_en_2, fl_write_en_1, fl_write_en_0}), 32'b111);
        step_check();
        apply(3'b000, 1, 3'b000, 0, 0);
        chk("fr_we2", 32'({fl_write_en_2, fl_write_en_1, fl_write_en_0}), 32'b001);
        step_check();
        chk("fr_run", 32'(recovering), 32'd0);

        // Reset in the middle of recovery with a backlog of five.
        do_reset();
        apply(3'b000, 1, 3'b000, 1, 5); step_check();
        chk("mr_pend", 32'(pending_free), 32'd5);
        apply(3'b111, 1, 3'b111, 0, 0);
        rst = 1'b1;
        #1;
        chk("mr_recov", 32'(recovering), 32'd0);
        chk("mr_pend0", 32'(pending_free), 32'd0);
        chk("mr_en",    32'({fl_write_en_2, fl_write_en_1, fl_write_en_0, fl_read_en_2, fl_read_en_1, fl_read_en_0}), 32'd0);
        chk("mr_ovf",   32'(overflow_err), 32'd0);
        do_reset();

        // Backlog beyond the depth saturates and sets the sticky error.
        apply(3'b000, 1, 3'b000, 1, 40); step_check();
        chk("ovf_set",  32'(overflow_err), 32'd1);
        chk("ovf_pend", 32'(pending_free), 32'd32);
        apply(3'b000, 1, 3'b000, 0, 0); step_check();
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // Table-driven sequence from a fresh reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].req, tbl[i].rdy, tbl[i].cfe, tbl[i].fl, tbl[i].ffc);
            chk($sformatf("tbl%0d_grant", i), 32'(alloc_grant), 32'(tbl[i].e_grant));
            chk($sformatf("tbl%0d_stall", i), 32'(alloc_stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_we", i), 32'({fl_write_en_2, fl_write_en_1, fl_write_en_0}), 32'(tbl[i].e_we));
            step_check();
            chk($sformatf("tbl%0d_pend", i), 32'(pending_free), 32'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_recov", i), 32'(recovering), 32'(tbl[i].e_rec));
        end

        // Random traffic that never returns more tags than are outstanding.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [2:0] rq, cf;
            logic       rd, fl;
            int         outst, fc;
            outst = DEPTH - fl_cnt - m_pend;
            rq = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 4) != 0);
            cf = 3'($urandom_range(0, 7));
            if ($countones(cf) > outst) cf = 3'b000;
            fl = ($urandom_range(0, 15) == 0);
            fc = fl ? int'($urandom_range(0, outst - $countones(cf))) : 0;
            apply(rq, rd, cf, fl, fc);
            step_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
